// File: rtl/routine_selector.sv
// Debounced "next" button picks one of four routine buses for the board pins; every switch blanks the output and pulses RoutineReset.
// RUN output is one register behind the bus. No backpressure. Define AUTO_CYCLE_EN to add Tick-driven auto-advance.
module routine_selector #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_CYCLES    = 4,
  parameter int DWELL_TICKS     = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [46:0] Bus0,
  input  logic [46:0] Bus1,
  input  logic [46:0] Bus2,
  input  logic [46:0] Bus3,
  input  logic        NextBtn,
  input  logic        Tick,
  output logic [17:0] LedOut,
  output logic [27:0] SsdOut,
  output logic [1:0]  RoutineSel,
  output logic        RoutineReset
);

  typedef enum logic {BLANK, RUN} state_t;

  state_t      state;
  logic [7:0]  blankCnt;
  logic        syncA, syncB;
  logic [7:0]  dbCnt;
  logic        dbLevel, dbLevelPrev;
  logic        press, advance;
  logic [45:0] selBus;
  logic        unusedBits;

  // Two-flop synchroniser followed by the counting debouncer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      syncA       <= 1'b0;
      syncB       <= 1'b0;
      dbCnt       <= 8'd0;
      dbLevel     <= 1'b0;
      dbLevelPrev <= 1'b0;
    end else begin
      syncA       <= NextBtn;
      syncB       <= syncA;
      dbLevelPrev <= dbLevel;
      if (syncB == dbLevel) begin
        dbCnt <= 8'd0;
      end else if (dbCnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        dbLevel <= syncB;
        dbCnt   <= 8'd0;
      end else begin
        dbCnt <= dbCnt + 8'd1;
      end
    end
  end

  assign press = dbLevel & ~dbLevelPrev;

`ifdef AUTO_CYCLE_EN
  logic [9:0] dwellCnt;
  logic       dwellHit;

  assign dwellHit = (state == RUN) && Tick && (dwellCnt == 10'(DWELL_TICKS - 1));
  assign advance  = press | dwellHit;
  assign unusedBits = ^{Bus0[46], Bus1[46], Bus2[46], Bus3[46]};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      dwellCnt <= 10'd0;
    end else if (press || dwellHit || state != RUN) begin
      dwellCnt <= 10'd0;
    end else if (Tick) begin
      dwellCnt <= dwellCnt + 10'd1;
    end
  end
`else
  assign advance    = press;
  assign unusedBits = ^{Bus0[46], Bus1[46], Bus2[46], Bus3[46], Tick};
`endif

  always_comb begin
    selBus = Bus0[45:0];
    case (RoutineSel)
      2'd0: selBus = Bus0[45:0];
      2'd1: selBus = Bus1[45:0];
      2'd2: selBus = Bus2[45:0];
      2'd3: selBus = Bus3[45:0];
      default: selBus = Bus0[45:0];
    endcase
  end

  // The bus is loaded on the last BLANK cycle so RUN shows it immediately.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= BLANK;
      blankCnt     <= 8'(BLANK_CYCLES);
      RoutineSel   <= 2'd0;
      RoutineReset <= 1'b1;
      LedOut       <= 18'd0;
      SsdOut       <= '1;
    end else begin
      RoutineReset <= 1'b0;
      case (state)
        BLANK: begin
          blankCnt <= blankCnt - 8'd1;
          if (blankCnt == 8'd1) begin
            state  <= RUN;
            LedOut <= selBus[45:28];
            SsdOut <= selBus[27:0];
          end else begin
            LedOut <= 18'd0;
            SsdOut <= '1;
          end
        end
        RUN: begin
          if (advance) begin
            state        <= BLANK;
            blankCnt     <= 8'(BLANK_CYCLES);
            RoutineSel   <= RoutineSel + 2'd1;
            RoutineReset <= 1'b1;
            LedOut       <= 18'd0;
            SsdOut       <= '1;
          end else begin
            LedOut <= selBus[45:28];
            SsdOut <= selBus[27:0];
          end
        end
        default: begin
          state    <= BLANK;
          blankCnt <= 8'(BLANK_CYCLES);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_routine_selector.sv
// Bench for routine_selector: directed vectors and hand-written button sequences.
module tb_routine_selector;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [46:0] Bus0, Bus1, Bus2, Bus3;
  logic        NextBtn, NextBtnB, Tick;
  logic [17:0] LedOut, LedB;
  logic [27:0] SsdOut, SsdB;
  logic [1:0]  RoutineSel, SelB;
  logic        RoutineReset, RstB;

  int tests = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  routine_selector dut (
    .Clock(Clock), .Reset(Reset), .Bus0(Bus0), .Bus1(Bus1), .Bus2(Bus2), .Bus3(Bus3),
    .NextBtn(NextBtn), .Tick(Tick), .LedOut(LedOut), .SsdOut(SsdOut),
    .RoutineSel(RoutineSel), .RoutineReset(RoutineReset)
  );

  // Short debounce with a long blank lets a second press land inside BLANK.
  routine_selector #(.DEBOUNCE_CYCLES(2), .BLANK_CYCLES(30)) dutB (
    .Clock(Clock), .Reset(Reset), .Bus0(Bus0), .Bus1(Bus1), .Bus2(Bus2), .Bus3(Bus3),
    .NextBtn(NextBtnB), .Tick(Tick), .LedOut(LedB), .SsdOut(SsdB),
    .RoutineSel(SelB), .RoutineReset(RstB)
  );

`ifdef AUTO_CYCLE_EN
  logic        NextBtnC, TickC;
  logic [17:0] LedC;
  logic [27:0] SsdC;
  logic [1:0]  SelC;
  logic        RstC;

  routine_selector #(.DWELL_TICKS(3)) dutC (
    .Clock(Clock), .Reset(Reset), .Bus0(Bus0), .Bus1(Bus1), .Bus2(Bus2), .Bus3(Bus3),
    .NextBtn(NextBtnC), .Tick(TickC), .LedOut(LedC), .SsdOut(SsdC),
    .RoutineSel(SelC), .RoutineReset(RstC)
  );
`endif

  typedef struct {
    logic [46:0] bus;
    logic [17:0] led;
    logic [27:0] ssd;
  } vec_t;

  vec_t vecs[4];

  localparam logic [46:0] BUS0 = {1'b0, 18'h0000F, 28'h0000000};
  localparam logic [46:0] BUS1 = {1'b0, 18'h3FFFF, 28'hFFFFFFF};
  localparam logic [46:0] BUS2 = {1'b0, 18'h00AAA, 28'h5555555};
  localparam logic [46:0] BUS3 = {1'b0, 18'h15555, 28'h0F0F0F0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pressMain(input logic [1:0] expSel, input logic [17:0] expLed);
    NextBtn = 1'b1;
    step(19);
    chk("walk_sel", RoutineSel, expSel);
    step(6);
    chk("walk_led", LedOut, expLed);
    NextBtn = 1'b0;
    step(25);
  endtask

`ifdef AUTO_CYCLE_EN
  task automatic tickPulse();
    step(9);
    TickC = 1'b1;
    step(1);
    TickC = 1'b0;
  endtask
`endif

  initial begin
    vecs[0] = '{{1'b1, 18'h2A5A5, 28'h1234567}, 18'h2A5A5, 28'h1234567};
    vecs[1] = '{{1'b0, 18'h3FFFF, 28'h0000000}, 18'h3FFFF, 28'h0000000};
    vecs[2] = '{{1'b1, 18'h00001, 28'hFFFFFFE}, 18'h00001, 28'hFFFFFFE};
    vecs[3] = '{{1'b0, 18'h20000, 28'h8000001}, 18'h20000, 28'h8000001};

    Reset = 1'b0; NextBtn = 1'b0; NextBtnB = 1'b0; Tick = 1'b0;
    Bus0 = BUS0; Bus1 = BUS1; Bus2 = BUS2; Bus3 = BUS3;
`ifdef AUTO_CYCLE_EN
    NextBtnC = 1'b0; TickC = 1'b0;
`endif
    step(1);

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_led", LedOut, 18'h0);
      chk("rst_ssd", SsdOut, 28'hFFFFFFF);
      chk("rst_pulse", RoutineReset, 1'b1);
      chk("rst_sel", RoutineSel, 2'd0);
    end
    Reset = 1'b1;
    step(1);
    chk("rel_pulse", RoutineReset, 1'b0);
    step(2);
    chk("rel_blank_led", LedOut, 18'h0);
    chk("rel_blank_ssd", SsdOut, 28'hFFFFFFF);
    step(1);
    chk("rel_bus0_led", LedOut, 18'h0000F);
    chk("rel_bus0_ssd", SsdOut, 28'h0000000);

    // RUN pass-through with one register of latency, bit 46 ignored
    for (int i = 0; i < 4; i++) begin
      Bus0 = vecs[i].bus;
      step(1);
      chk("vec_led", LedOut, vecs[i].led);
      chk("vec_ssd", SsdOut, vecs[i].ssd);
    end
    Bus0 = BUS0;
    step(2);

    // Clean press: selection moves 19 cycles after the raw edge
    NextBtn = 1'b1;
    step(18);
    chk("press_early_sel", RoutineSel, 2'd0);
    chk("press_early_led", LedOut, 18'h0000F);
    step(1);
    chk("press_sel", RoutineSel, 2'd1);
    chk("press_pulse", RoutineReset, 1'b1);
    chk("press_blank0", LedOut, 18'h0);
    step(1);
    chk("press_pulse_end", RoutineReset, 1'b0);
    step(2);
    chk("press_blank3_led", LedOut, 18'h0);
    chk("press_blank3_ssd", SsdOut, 28'hFFFFFFF);
    step(1);
    chk("press_bus1_led", LedOut, 18'h3FFFF);
    NextBtn = 1'b0;
    step(25);
    chk("release_no_press", RoutineSel, 2'd1);

    // Selection walk with wrap
    pressMain(2'd2, 18'h00AAA);
    pressMain(2'd3, 18'h15555);
    pressMain(2'd0, 18'h0000F);
    pressMain(2'd1, 18'h3FFFF);

    // Bouncing button followed by a steady hold
    for (int i = 0; i < 12; i++) begin
      NextBtn = ~NextBtn;
      step(5);
    end
    chk("bounce_none", RoutineSel, 2'd1);
    NextBtn = 1'b1;
    step(18);
    chk("bounce_early", RoutineSel, 2'd1);
    step(1);
    chk("bounce_one", RoutineSel, 2'd2);
    step(40);
    chk("bounce_only_one", RoutineSel, 2'd2);
    NextBtn = 1'b0;
    step(25);

    // Second press during BLANK is dropped, not queued
    NextBtnB = 1'b1;
    step(5);
    chk("drop_first", SelB, 2'd1);
    NextBtnB = 1'b0;
    step(6);
    NextBtnB = 1'b1;
    step(8);
    chk("drop_in_blank", SelB, 2'd1);
    step(20);
    chk("drop_after_blank", SelB, 2'd1);
    chk("drop_run_led", LedB, 18'h3FFFF);
    NextBtnB = 1'b0;
    step(6);
    NextBtnB = 1'b1;
    step(8);
    chk("drop_next_press", SelB, 2'd2);
    NextBtnB = 1'b0;

    // Reset mid-debounce discards the partial count
    NextBtn = 1'b1;
    step(12);
    Reset = 1'b0;
    step(1);
    chk("midrst_sel", RoutineSel, 2'd0);
    chk("midrst_pulse", RoutineReset, 1'b1);
    Reset = 1'b1;
    step(18);
    chk("midrst_no_early", RoutineSel, 2'd0);
    step(1);
    chk("midrst_full", RoutineSel, 2'd1);
    NextBtn = 1'b0;
    step(25);

`ifdef AUTO_CYCLE_EN
    // Auto-advance on the 3rd Tick in RUN
    tickPulse();
    chk("auto_t1", SelC, 2'd0);
    tickPulse();
    chk("auto_t2", SelC, 2'd0);
    tickPulse();
    chk("auto_t3", SelC, 2'd1);
    chk("auto_pulse", RstC, 1'b1);
    step(10);
    // A press after 2 Ticks restarts the count
    tickPulse();
    tickPulse();
    chk("auto_pre_press", SelC, 2'd1);
    NextBtnC = 1'b1;
    step(19);
    chk("auto_press", SelC, 2'd2);
    NextBtnC = 1'b0;
    step(25);
    tickPulse();
    tickPulse();
    chk("auto_restart_t2", SelC, 2'd2);
    tickPulse();
    chk("auto_restart_t3", SelC, 2'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
